pc_gen: RTL
===========

Name: pc_gen

Overview:
Parametrised fetch program-counter generator; successor to the single-register PC.
- Holds the architectural fetch PC.
- Issues valid/ready fetch requests to instruction memory.
- Selects the next PC from sequential increment, branch/jump redirect or trap vector.
- Buffers redirects that arrive while a request is outstanding, and detects misaligned targets.
- Sits between the EX/trap logic and the IF stage; driven by the hazard unit.

Parameters:
XLEN, 32, address/PC width.
RESET_VEC, 0, PC value loaded on reset.
IALIGN, 32, instruction alignment in bits: 32 gives a step of 4, 16 (compressed) gives a step of 2.

Ports:
clk  in  1  clock.
rstN  in  1  asynchronous active-low reset.
pcWrite  in  1  hazard unit; 0 = stall, hold PC.
redirectValid  in  1  branch/jump taken from EX.
redirectTarget  in  XLEN  branch/jump target.
trapValid  in  1  trap/exception entry.
trapVector  in  XLEN  trap handler address.
imemReqValid  out  1  fetch request valid.
imemReqReady  in  1  instruction memory accepts request.
imemAddr  out  XLEN  fetch address (= pcOut).
pcOut  out  XLEN  current fetch PC.
pcPlusStep  out  XLEN  pcOut + STEP, combinational (link value).
misalignErr  out  1  one-cycle pulse: selected target misaligned.
misalignAddr  out  XLEN  offending target, held until next error or reset.

Behaviour:
- Reset (async, rstN=0):
  - pcOut=RESET_VEC; state=BOOT.
  - pending buffer cleared.
  - misalignErr=0, misalignAddr=0, imemReqValid=0.
  - Reset mid-request abandons the request; memory must tolerate this.
- STEP = IALIGN/8. Misaligned means bits[1:0]!=0 for IALIGN=32, or bit0!=0 for IALIGN=16. Additions wrap modulo 2^XLEN.
- States:
  - BOOT: one cycle after reset release; imemReqValid=0; then go to FETCH.
  - FETCH: imemReqValid=1, imemAddr=pcOut.
  - HALT: imemReqValid=0; entered after a misaligned target; left only by trapValid.
- Handshake:
  - accept = imemReqValid && imemReqReady.
  - pcOut changes only on an advance, so imemAddr stays stable while valid is high and ready is low.
  - Exception: trap in HALT, below.
- Advance, in FETCH: accept && (pcWrite || pendValid || redirectValid || trapValid). A redirect or trap overrides a stall (flush).
- Next-PC priority at advance:
  - trapValid, then pending trap, then redirectValid, then pending redirect, then pcOut+STEP.
  - A same-cycle redirect or trap wins over the pending entry; the pending buffer is cleared on every advance.
- Pending buffer, when no advance occurs in FETCH:
  - trapValid captures {trap, trapVector}; this overwrites any pending entry.
  - redirectValid captures {redirect, redirectTarget} only if no trap is pending.
  - A newer redirect overwrites an older pending redirect.
  - Trap beats redirect in the same cycle.
- Trap vector: low misalignment bits are forced to 0 before loading; a trap never raises misalignErr.
- Misaligned redirect selected at advance:
  - pcOut is not updated.
  - misalignErr=1 for exactly 1 cycle; misalignAddr=target.
  - state goes to HALT; pending cleared.
  - In HALT, redirects are ignored. trapValid loads the aligned trapVector into pcOut next cycle and returns to FETCH.
- Stall: pcWrite=0 with no redirect/trap means PC holds. imemReqValid stays 1; the same address is re-accepted each time ready is asserted (IF discards).
- Latency: a redirect or trap with accept in cycle N gives imemAddr=target in cycle N+1.

Decomposition:
- Shared package riscv_pkg holds:
  - pc_state_t enum {BOOT, FETCH, HALT};
  - redirect kind enum {NONE, REDIR, TRAP};
  - a STEP function of IALIGN and a misalignment-mask function.
- One sub-module, pc_redirect_buf: the pending register with trap-over-redirect priority, capture/clear controls, outputs pendValid/pendKind/pendTarget.

Test Plan:
1. Reset, then ready=1, pcWrite=1, RESET_VEC=0x100 -> BOOT for 1 cycle; imemAddr 0x100, 0x104, 0x108 on consecutive cycles; pcPlusStep = imemAddr+4.
2. ready=0 for 3 cycles, redirect to 0x200 in the 2nd cycle, then ready=1 -> imemAddr held at its value throughout; the accept advances to 0x200, then 0x204.
3. Held request: redirect 0x300 then trap 0x80 pending, plus a later redirect 0x400 -> next PC 0x80; the 0x400 redirect is not taken.
4. pcWrite=0 with ready=1 for 4 cycles -> imemAddr constant, valid high; redirectValid to 0x500 while stalled -> 0x500 next cycle.
5. IALIGN=32, redirect to 0x1002 -> misalignErr pulses 1 cycle; misalignAddr=0x1002; pcOut unchanged; imemReqValid=0. trapVector=0x83 -> pcOut=0x80, FETCH resumes.
6. IALIGN=16: sequence steps by 2. 0x...FFFE + 2 wraps to 0. Assert rstN=0 mid-stall with pending redirect -> pcOut=RESET_VEC immediately; after release, pending is gone.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types and alignment helpers.
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    HALT
  } pc_state_t;

  typedef enum logic [1:0] {
    NONE,
    REDIR,
    TRAP
  } redir_kind_t;

  // Byte distance between consecutive instructions.
  function automatic int unsigned step_of(input int unsigned ialign);
    return ialign / 8;
  endfunction

  // Low address bits that must be zero for an aligned target.
  function automatic logic [1:0] misalign_mask(input int unsigned ialign);
    return (ialign == 16) ? 2'b01 : 2'b11;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// Instruction-memory fetch request channel (valid/ready).
interface pc_gen_if #(
  parameter int unsigned XLEN = 32
);
  logic            imemReqValid;
  logic            imemReqReady;
  logic [XLEN-1:0] imemAddr;

  modport master (output imemReqValid, output imemAddr, input imemReqReady);
  modport slave  (input imemReqValid, input imemAddr, output imemReqReady);
endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry pending redirect/trap holder; a trap is never displaced by a redirect.
module pc_redirect_buf
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            clr,
  input  logic            capTrap,
  input  logic            capRedir,
  input  logic [XLEN-1:0] trapTarget,
  input  logic [XLEN-1:0] redirTarget,
  output logic            pendValid,
  output redir_kind_t     pendKind,
  output logic [XLEN-1:0] pendTarget
);

  redir_kind_t     kind_q, kind_d;
  logic [XLEN-1:0] tgt_q, tgt_d;

  // Next entry: clear beats capture, trap beats redirect, pending trap blocks redirects.
  always_comb begin
    kind_d = kind_q;
    tgt_d  = tgt_q;
    if (clr) begin
      kind_d = NONE;
      tgt_d  = '0;
    end else if (capTrap) begin
      kind_d = TRAP;
      tgt_d  = trapTarget;
    end else if (capRedir && (kind_q != TRAP)) begin
      kind_d = REDIR;
      tgt_d  = redirTarget;
    end
  end

  // Entry register, emptied by reset.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      kind_q <= NONE;
      tgt_q  <= '0;
    end else begin
      kind_q <= kind_d;
      tgt_q  <= tgt_d;
    end
  end

  assign pendValid  = (kind_q != NONE);
  assign pendKind   = kind_q;
  assign pendTarget = tgt_q;

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: sequential step, redirect/trap selection, misalignment halt.
module pc_gen
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     IALIGN    = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            pcWrite,
  input  logic            redirectValid,
  input  logic [XLEN-1:0] redirectTarget,
  input  logic            trapValid,
  input  logic [XLEN-1:0] trapVector,
  pc_gen_if.master        imem,
  output logic [XLEN-1:0] pcOut,
  output logic [XLEN-1:0] pcPlusStep,
  output logic            misalignErr,
  output logic [XLEN-1:0] misalignAddr
);

  localparam logic [XLEN-1:0] STEP = XLEN'(step_of(IALIGN));
  localparam logic [XLEN-1:0] MASK = XLEN'(misalign_mask(IALIGN));

  pc_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] errAddr_q, errAddr_d;

  logic            pendValid;
  redir_kind_t     pendKind;
  logic [XLEN-1:0] pendTarget;
  logic            bufClr, capTrap, capRedir;
  logic            accept, advance;
  redir_kind_t     selKind;
  logic [XLEN-1:0] selTarget;
  logic [XLEN-1:0] trapAligned;

  assign trapAligned = trapVector & ~MASK;

  pc_redirect_buf #(
    .XLEN(XLEN)
  ) u_buf (
    .clk        (clk),
    .rstN       (rstN),
    .clr        (bufClr),
    .capTrap    (capTrap),
    .capRedir   (capRedir),
    .trapTarget (trapAligned),
    .redirTarget(redirectTarget),
    .pendValid  (pendValid),
    .pendKind   (pendKind),
    .pendTarget (pendTarget)
  );

  // Next-state, next-PC and pending-buffer control.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    err_d     = 1'b0;
    errAddr_d = errAddr_q;
    bufClr    = 1'b0;
    capTrap   = 1'b0;
    capRedir  = 1'b0;

    imem.imemReqValid = (state_q == FETCH);
    accept  = imem.imemReqValid && imem.imemReqReady;
    advance = accept && (pcWrite || pendValid || redirectValid || trapValid);

    selKind   = NONE;
    selTarget = pc_q + STEP;
    if (trapValid) begin
      selKind   = TRAP;
      selTarget = trapAligned;
    end else if (pendKind == TRAP) begin
      selKind   = TRAP;
      selTarget = pendTarget;
    end else if (redirectValid) begin
      selKind   = REDIR;
      selTarget = redirectTarget;
    end else if (pendKind == REDIR) begin
      selKind   = REDIR;
      selTarget = pendTarget;
    end

    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        if (advance) begin
          bufClr = 1'b1;
          if ((selKind == REDIR) && (|(selTarget & MASK))) begin
            err_d     = 1'b1;
            errAddr_d = selTarget;
            state_d   = HALT;
          end else begin
            pc_d = selTarget;
          end
        end else begin
          capTrap  = trapValid;
          capRedir = redirectValid;
        end
      end
      HALT: begin
        if (trapValid) begin
          pc_d    = trapAligned;
          state_d = FETCH;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Architectural PC, FSM state and misalignment report registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= BOOT;
      pc_q      <= RESET_VEC;
      err_q     <= 1'b0;
      errAddr_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      err_q     <= err_d;
      errAddr_q <= errAddr_d;
    end
  end

  assign imem.imemAddr = pc_q;
  assign pcOut         = pc_q;
  assign pcPlusStep    = pc_q + STEP;
  assign misalignErr   = err_q;
  assign misalignAddr  = errAddr_q;

endmodule
